alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor of the 4-bit combinational ALU. Computes arithmetic (add, subtract, increment, two's-complement negate) and bitwise logic on WIDTH-bit operands, plus an optional multi-cycle shift-add multiply. Uses a start/done handshake and holds result and flags in registers. Sits between the operand registers and the register-file write-back of the datapath.

## Interface
- WIDTH, 8: operand/result width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; samples op, A and B on the same edge.
- op  input  3  operation select (see Operation).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- R  output  WIDTH  result, low half of product for MUL.
- RH  output  WIDTH  high half of product for MUL; 0 for all other ops.
- zero  output  1  result equals 0 (full 2·WIDTH product for MUL).
- carry  output  1  carry out; see per-op rules.
- sign  output  1  MSB of R (MSB of RH for MUL).
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse when R and the flags are updated.

## Operation
- Op encoding:
  - 000 ADD A+B.
  - 001 SUB A+~B+1.
  - 010 INC A+1.
  - 011 NEG ~A+1.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 MUL, unsigned A×B.
- Arithmetic is computed at WIDTH+1 bits.
  - carry = bit WIDTH of that sum.
  - For SUB, carry=1 means no borrow.
  - For NEG, carry=1 only when A=0.
- overflow for ADD/SUB/INC/NEG: operand sign bits agree (after B inversion for SUB) and the result sign differs. NEG overflows only for A=100…0.
- Logic ops: carry=0, overflow=0.
- MUL: carry = |RH, overflow=0.
- FSM states:
  - IDLE: start with op≠111 writes R/RH/flags and pulses done on the next edge, then stays in IDLE. start with op=111 latches the operands, clears the accumulator, loads the counter with WIDTH and moves to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half, then shift right 1 (carry into MSB). The counter decrements. When the counter reaches 1, this edge writes R/RH/flags, pulses done, and returns to IDLE.
- start while busy=1 is ignored, with no queueing.
- R, RH and the flags hold their values between operations.

## Timing
- Reset values: R=0, RH=0, zero=0, carry=0, sign=0, overflow=0, busy=0, done=0, FSM=IDLE, counter=0.
- Single-cycle ops:
  - start sampled at edge k; results and done=1 visible after edge k.
  - done drops after edge k+1 unless start is high again.
  - Back-to-back starts every cycle are legal and give one done per start.
- MUL:
  - start sampled at edge k; busy=1 after edges k … k+WIDTH−1.
  - Results, done=1 and busy=0 after edge k+WIDTH, giving a latency of WIDTH cycles.
  - A new start may be sampled at edge k+WIDTH, the same edge that completes the multiply.
- Reset asserted mid-MUL aborts immediately. All outputs return to reset values and no done is produced.
- done and busy are never both 1.

## Configuration
- ALU_MUL_EN defined: MUL is built as described above.
- ALU_MUL_EN undefined:
  - No multiplier, accumulator or counter is built; busy is tied to 0.
  - op=111 completes in 1 cycle with R=0, RH=0, zero=1, carry=0, sign=0, overflow=0.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 -> after 1 edge: R=0x80, sign=1, overflow=1, carry=0, zero=0, done pulse of exactly 1 cycle.
- SUB 0x05−0x05 -> R=0x00, zero=1, carry=1, overflow=0. SUB 0x00−0x01 -> R=0xFF, carry=0, sign=1.
- NEG 0x00 -> R=0x00, carry=1, zero=1. NEG 0x80 -> R=0x80, overflow=1. INC 0xFF -> R=0x00, carry=1, zero=1.
- MUL 0xFF×0xFF (ALU_MUL_EN) -> busy=1 for 8 cycles, then RH=0xFE, R=0x01, carry=1, done exactly 8 edges after start. A start of ADD issued at cycle 3 is ignored.
- Reset pulse during MUL cycle 4 -> all outputs 0 asynchronously, no done. A following AND 0xF0&0x3C gives R=0x30 after 1 edge.
- Without ALU_MUL_EN: op=111 with A=0x12, B=0x34 -> after 1 edge: R=0, RH=0, zero=1, busy never asserted.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- registered WIDTH-bit ALU with start/done handshake.
//
// Supported operations:
//   - single-cycle: add, subtract, increment, negate, and, or, xor
//   - optional multi-cycle unsigned shift-add multiply (WIDTH cycles)
// The result and the flags are held in registers between operations.
//
// Build option:
//   ALU_MUL_EN : when defined, builds the multiplier datapath and FSM.
//                When undefined, op=111 completes in one cycle with
//                R=0, RH=0, zero=1 and all other flags 0, and busy is
//                tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   operation request; op, A and B are sampled with it
//   op[2:0]   in   operation select (000 ADD ... 111 MUL)
//   A, B      in   WIDTH-bit operands
//   R         out  result (low half of the product for MUL)
//   RH        out  high half of the product for MUL, 0 otherwise
//   zero      out  result is zero (full 2*WIDTH product for MUL)
//   carry     out  carry out (no-borrow for SUB, |RH for MUL)
//   sign      out  MSB of R (MSB of RH for MUL)
//   overflow  out  two's-complement signed overflow
//   busy      out  a multiply is in progress
//   done      out  one-cycle pulse when R and the flags were updated
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] RH,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // ------------------------------------------------------------------
    // Single-cycle datapath. All four arithmetic ops are mapped onto one
    // adder x + y + cin so the carry and overflow rules are shared:
    //   SUB: y = ~B, cin = 1    INC: y = 0, cin = 1    NEG: x = ~A, y = 0, cin = 1
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sc_r;
    logic             sc_c;
    logic             sc_ov;

    always_comb begin
        add_x   = A;
        add_y   = B;
        add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                add_y   = ~B;
                add_cin = 1'b1;
            end
            OP_INC: begin
                add_y   = '0;
                add_cin = 1'b1;
            end
            OP_NEG: begin
                add_x   = ~A;
                add_y   = '0;
                add_cin = 1'b1;
            end
            default: ;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    end

    always_comb begin
        sc_r  = '0;
        sc_c  = 1'b0;
        sc_ov = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_NEG: begin
                sc_r  = add_sum[WIDTH-1:0];
                sc_c  = add_sum[WIDTH];
                // Signed overflow: adder inputs share a sign, result differs.
                sc_ov = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            OP_AND: sc_r = A & B;
            OP_OR:  sc_r = A | B;
            OP_XOR: sc_r = A ^ B;
            // Only reached as a single-cycle op when the multiplier is not
            // built: the result is all zeros.
            OP_MUL: sc_r = '0;
        endcase
    end

    logic sc_write;   // single-cycle op completes on this edge

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier. acc_q holds {partial high half, multiplier};
    // the multiplier bits are consumed from the LSB while product bits
    // shift in from the top, so after WIDTH steps acc_q is the product.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     hi_sum;
    logic               mul_load;
    logic               mul_step;
    logic               mul_last;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. A start seen in S_MUL is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && op == OP_MUL)  state_d = S_MUL;
            S_MUL:   if (cnt_q == CW'(1))         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state_q == S_MUL);
        mul_load = (state_q == S_IDLE) && start && (op == OP_MUL);
        mul_step = (state_q == S_MUL);
        mul_last = (state_q == S_MUL) && (cnt_q == CW'(1));
        sc_write = (state_q == S_IDLE) && start && (op != OP_MUL);
    end

    // One multiply step: conditional add into the high half, then shift
    // right with the adder carry entering the MSB.
    always_comb begin
        hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d  = {hi_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (mul_load) begin
            mcand_q <= A;
            acc_q   <= {{WIDTH{1'b0}}, B};
            cnt_q   <= CW'(WIDTH);
        end else if (mul_step) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_q - CW'(1);
        end
    end
`else
    assign busy     = 1'b0;
    assign sc_write = start;
`endif

    // ------------------------------------------------------------------
    // Result and flag registers: hold until the next completing op.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R        <= '0;
            RH       <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else if (sc_write) begin
            R        <= sc_r;
            RH       <= '0;
            zero     <= (sc_r == '0);
            carry    <= sc_c;
            sign     <= sc_r[WIDTH-1];
            overflow <= sc_ov;
            done     <= 1'b1;
`ifdef ALU_MUL_EN
        end else if (mul_last) begin
            R        <= acc_d[WIDTH-1:0];
            RH       <= acc_d[2*WIDTH-1:WIDTH];
            zero     <= (acc_d == '0);
            carry    <= |acc_d[2*WIDTH-1:WIDTH];
            sign     <= acc_d[2*WIDTH-1];
            overflow <= 1'b0;
            done     <= 1'b1;
`endif
        end else begin
            done     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W    = 8;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A, B, R, RH;
    logic         zero, carry, sign, overflow, busy, done;

    int errors = 0;
    int checks = 0;

    // Expected {RH, R, zero, carry, sign, overflow}
    logic [2*W+3:0] exp_q;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .R        (R),
        .RH       (RH),
        .zero     (zero),
        .carry    (carry),
        .sign     (sign),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic logic [2*W+3:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa, sb, full, p;
        logic [W-1:0] r, rh;
        logic z, c, s, ov;
        sa = $signed(a);
        sb = $signed(b);
        full = 0;
        r = '0; rh = '0; z = 1'b0; c = 1'b0; s = 1'b0; ov = 1'b0;
        case (o)
            3'd0: begin
                full = int'(a) + int'(b);
                r  = full[W-1:0];
                c  = full[W];
                ov = (sa + sb > SMAX) || (sa + sb < SMIN);
            end
            3'd1: begin
                full = int'(a) - int'(b);
                r  = full[W-1:0];
                c  = (a >= b);
                ov = (sa - sb > SMAX) || (sa - sb < SMIN);
            end
            3'd2: begin
                full = int'(a) + 1;
                r  = full[W-1:0];
                c  = full[W];
                ov = (sa + 1 > SMAX);
            end
            3'd3: begin
                full = -int'(a);
                r  = full[W-1:0];
                c  = (a == 0);
                ov = (-sa > SMAX);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: begin
`ifdef ALU_MUL_EN
                p  = int'(a) * int'(b);
                r  = p[W-1:0];
                rh = p[2*W-1:W];
                c  = (rh != 0);
`endif
            end
        endcase
        if (o == 3'd7) begin
            z = (r == 0) && (rh == 0);
            s = rh[W-1];
        end else begin
            z = (r == 0);
            s = r[W-1];
        end
        return {rh, r, z, c, s, ov};
    endfunction

    function automatic logic [2*W+3:0] outs();
        return {RH, R, zero, carry, sign, overflow};
    endfunction

    task automatic single(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q = model(o, a, b);
        $display("%s op=%0d A=%02h B=%02h R=%02h RH=%02h z=%b c=%b s=%b v=%b",
                 tag, o, a, b, R, RH, zero, carry, sign, overflow);
        check({tag, ".res"}, outs(), exp_q);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); A = W'($urandom); B = W'($urandom);
        @(posedge clk); #1;
        check({tag, ".done_low"}, done, 1'b0);
        check({tag, ".hold"}, outs(), exp_q);
    endtask

`ifdef ALU_MUL_EN
    // Issues a multiply; if ign_at > 0 an ADD start is driven for one cycle
    // at that cycle of the multiply and must be ignored.
    task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_at,
                          input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; op = 3'd7; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        check({tag, ".busy0"}, {busy, done}, 2'b10);
        while (lat < 3 * W) begin
            @(negedge clk);
            if (lat + 1 == ign_at) begin
                start = 1'b1; op = 3'd0; A = 8'h01; B = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done) break;
            check({tag, ".busy"}, busy, 1'b1);
        end
        start = 1'b0;
        exp_q = model(3'd7, a, b);
        $display("%s op=7 A=%02h B=%02h R=%02h RH=%02h z=%b c=%b s=%b v=%b lat=%0d",
                 tag, a, b, R, RH, zero, carry, sign, overflow, lat);
        check({tag, ".latency"}, 64'(lat), 64'(W));
        check({tag, ".busy_end"}, busy, 1'b0);
        check({tag, ".res"}, outs(), exp_q);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        exp_q = '0;
        @(posedge clk); #1;
        check("reset.outs", outs(), exp_q);
        check("reset.busy_done", {busy, done}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle("post_reset");

        // Directed corner cases
        single(3'd0, 8'h7F, 8'h01, "add_ovf");
        idle_cycle("add_ovf");
        single(3'd1, 8'h05, 8'h05, "sub_zero");
        single(3'd1, 8'h00, 8'h01, "sub_borrow");
        single(3'd3, 8'h00, 8'h00, "neg_zero");
        single(3'd3, 8'h80, 8'h00, "neg_min");
        single(3'd2, 8'hFF, 8'h00, "inc_wrap");
        single(3'd2, 8'h7F, 8'h00, "inc_ovf");
        single(3'd4, 8'hF0, 8'h3C, "and");
        single(3'd5, 8'hF0, 8'h3C, "or");
        single(3'd6, 8'hF0, 8'h3C, "xor");
        idle_cycle("logic");

`ifdef ALU_MUL_EN
        mul_op(8'hFF, 8'hFF, 3, "mul_ff");
        idle_cycle("mul_ff");
        mul_op(8'h00, 8'h37, 0, "mul_zero");

        // Reset during the multiply: outputs clear at once, no done.
        @(negedge clk);
        start = 1'b1; op = 3'd7; A = 8'hAB; B = 8'hCD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q = '0;
        check("mul_rst.outs", outs(), exp_q);
        check("mul_rst.busy_done", {busy, done}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + 2; i++) idle_cycle("mul_rst");
        single(3'd4, 8'hF0, 8'h3C, "and_after_rst");
`else
        single(3'd7, 8'h12, 8'h34, "mul_off");
        idle_cycle("mul_off");
`endif

        // Randomized mix, back-to-back where no idle cycle is drawn
        for (int n = 0; n < 150; n++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
`ifdef ALU_MUL_EN
            if (o == 3'd7) mul_op(W'($urandom), W'($urandom), 0, "rnd_mul");
            else           single(o, W'($urandom), W'($urandom), "rnd");
`else
            single(o, W'($urandom), W'($urandom), "rnd");
`endif
            if ($urandom_range(0, 3) == 0) idle_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
